// File: rtl/wshb_pkg.sv
// Shared Wishbone encodings, FSM state type and address-range helper for the
// RAM slave.
package wshb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } wshb_state_e;

   // True when every byte-address bit above the word index is zero.
   function automatic logic addr_in_range(input logic [31:0] adr,
                                          input int unsigned addr_width);
      return (adr >> (addr_width + 2)) == 32'd0;
   endfunction

endpackage

// File: rtl/wshb_ram_slave_if.sv
// Wishbone B4 slave-side bus bundle, used between a master and the RAM slave.
interface wshb_ram_slave_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_sm;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wshb_ram_bank.sv
// Word-wide storage with per-byte write enables and a registered read port;
// the array itself is never reset so it maps onto block RAM.
module wshb_ram_bank #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [31:0]           wr_data,
   input  logic [3:0]            wr_be
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0] mem [DEPTH];

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Output register holds its value unless a new read is launched.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone RAM slave: classic and incrementing-linear burst accesses with
// optional wait states ahead of the first beat, and err on out-of-range words.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no access in flight; a new request may be sampled
// ST_WAIT  | request accepted, wait-state down-counter running
// ST_BURST | ack or err is being presented for the current beat
module wshb_ram_slave
   import wshb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 0
) (
   input logic              sys_clk,
   input logic              sys_rst_n,
   wshb_ram_slave_if.slave  bus
);

   localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [WCW-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WCW'(WAIT_STATES - 1) : '0;
   localparam logic [WCW-1:0]        WCNT_ONE = WCW'(1);
   localparam logic [ADDR_WIDTH-1:0] WORD_ONE = ADDR_WIDTH'(1);

   wshb_state_e           state_q, state_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [WCW-1:0]        wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

   logic                  bus_act;
   logic                  req;
   logic                  start;
   logic                  burst_cont;
   logic                  cur_in_range;
   logic                  nxt_in_range;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic [31:0]           nxt_adr;

   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [31:0]           rd_data;
   logic                  wr_en;

   assign bus_act      = bus.cyc & bus.stb;
   assign req          = bus_act & ~ack_q & ~err_q & (state_q == ST_IDLE);
   assign cur_idx      = bus.adr[ADDR_WIDTH+1:2];
   assign nxt_adr      = bus.adr + 32'd4;
   assign cur_in_range = addr_in_range(bus.adr, ADDR_WIDTH);
   assign nxt_in_range = addr_in_range(nxt_adr, ADDR_WIDTH);

   // A beat being acked with cti=INCR on a linear burst promises another
   // beat at the next word; ack for it is registered before that address
   // appears, so the range test uses the predicted address.
   assign burst_cont = ack_q & bus_act & (bus.cti == CTI_INCR) &
                       (bus.bte == BTE_LINEAR);

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      wcnt_d  = wcnt_q;
      ptr_d   = ptr_q;
      rd_en   = 1'b0;
      rd_addr = cur_idx;
      start   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  start = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  wcnt_d  = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (!bus_act) begin
               state_d = ST_IDLE;
               wcnt_d  = '0;
            end else if (wcnt_q == '0) begin
               start = 1'b1;
            end else begin
               wcnt_d = wcnt_q - WCNT_ONE;
            end
         end
         ST_BURST: begin
            if (burst_cont) begin
               if (nxt_in_range) begin
                  ack_d   = 1'b1;
                  rd_en   = 1'b1;
                  rd_addr = ptr_q;
                  ptr_d   = ptr_q + WORD_ONE;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // First beat: launch the read at the master's word and point past it.
      if (start) begin
         state_d = ST_BURST;
         if (cur_in_range) begin
            ack_d   = 1'b1;
            rd_en   = 1'b1;
            rd_addr = cur_idx;
            ptr_d   = cur_idx + WORD_ONE;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         wcnt_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         wcnt_q  <= wcnt_d;
         ptr_q   <= ptr_d;
      end
   end

   // A write lands only on the edge that completes an acked beat.
   assign wr_en = ack_q & bus_act & bus.we;

   wshb_ram_bank #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bank (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_addr   (cur_idx),
      .wr_data   (bus.dat_ms),
      .wr_be     (bus.sel)
   );

   assign bus.dat_sm = rd_data;
   assign bus.ack    = ack_q;
   assign bus.err    = err_q;
   assign bus.rty    = 1'b0;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Randomised scoreboard bench for wshb_ram_slave: a no-wait-state instance and
// a two-wait-state instance share one master driver selected by dsel.
module tb_wshb_ram_slave;
   import wshb_pkg::*;

   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   always #5 sys_clk = ~sys_clk;

   wshb_ram_slave_if bus0 ();
   wshb_ram_slave_if bus2 ();

   wshb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
      .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .bus (bus0));
   wshb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut2 (
      .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .bus (bus2));

   logic        m_cyc, m_stb, m_we;
   logic [31:0] m_adr, m_dat;
   logic [3:0]  m_sel;
   logic [2:0]  m_cti;
   logic [1:0]  m_bte;
   int          dsel;

   assign bus0.cyc = m_cyc & (dsel == 0);
   assign bus0.stb = m_stb & (dsel == 0);
   assign bus2.cyc = m_cyc & (dsel == 1);
   assign bus2.stb = m_stb & (dsel == 1);
   assign bus0.we = m_we;   assign bus2.we = m_we;
   assign bus0.adr = m_adr; assign bus2.adr = m_adr;
   assign bus0.dat_ms = m_dat; assign bus2.dat_ms = m_dat;
   assign bus0.sel = m_sel; assign bus2.sel = m_sel;
   assign bus0.cti = m_cti; assign bus2.cti = m_cti;
   assign bus0.bte = m_bte; assign bus2.bte = m_bte;

   logic        s_ack, s_err;
   logic [31:0] s_dat;
   assign s_ack = (dsel == 1) ? bus2.ack    : bus0.ack;
   assign s_err = (dsel == 1) ? bus2.err    : bus0.err;
   assign s_dat = (dsel == 1) ? bus2.dat_sm : bus0.dat_sm;

   int checks = 0;
   int errors = 0;

   // Reference memory: key = dsel*DEPTH + word; absent key = contents unknown.
   bit [31:0] mdl [int];

   typedef struct {
      bit          is_err;
      bit          chk;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   function automatic int key(input logic [31:0] a);
      return dsel * DEPTH + int'((a >> 2) % DEPTH);
   endfunction

   function automatic bit in_rng(input logic [31:0] a);
      return a < 32'(4 * DEPTH);
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s);
      int k;
      logic [31:0] v;
      k = key(a);
      if (!mdl.exists(k)) begin
         if (s == 4'hF) mdl[k] = d;
         return;
      end
      v = mdl[k];
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      mdl[k] = v;
   endfunction

   task automatic push(input bit we_, input logic [31:0] a);
      exp_t e;
      e.is_err = !in_rng(a);
      e.chk    = 1'b0;
      e.data   = '0;
      if (!e.is_err && !we_ && mdl.exists(key(a))) begin
         e.chk  = 1'b1;
         e.data = mdl[key(a)];
      end
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, expv);
      end
   endtask

   // Monitor: every cycle with ack or err consumes one expected response.
   always @(negedge sys_clk) begin
      if (sys_rst_n === 1'b1 && (s_ack || s_err)) begin
         checks++;
         if (s_ack && s_err) begin
            errors++;
            $display("FAIL ack_err_overlap ack=%0b err=%0b required mutually exclusive", s_ack, s_err);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp ack=%0b err=%0b dat=0x%08h required no response", s_ack, s_err, s_dat);
         end else begin
            mon_e = exp_q.pop_front();
            if ((mon_e.is_err != s_err) || (mon_e.chk && s_dat !== mon_e.data)) begin
               errors++;
               $display("FAIL resp_mismatch got err=%0b dat=0x%08h required err=%0b dat=0x%08h (data checked=%0b)",
                        s_err, s_dat, mon_e.is_err, mon_e.data, mon_e.chk);
            end
         end
      end
   end

   task automatic classic(input bit we_, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output bit got_err,
                          output logic [31:0] rdata);
      m_cyc = 1; m_stb = 1; m_we = we_; m_adr = a; m_dat = d; m_sel = s;
      m_cti = CTI_CLASSIC; m_bte = BTE_LINEAR;
      push(we_, a);
      lat = 0; got_err = 0; rdata = '0;
      do begin
         @(posedge sys_clk); #1; lat++;
      end while (!(s_ack || s_err) && lat < 20);
      if (!(s_ack || s_err)) begin
         checks++; errors++;
         $display("FAIL classic_timeout adr=0x%08h no ack/err within %0d cycles", a, lat);
         exp_q.delete(exp_q.size() - 1);
      end else begin
         got_err = s_err;
         rdata   = s_dat;
         if (s_ack && we_) model_write(a, d, s);
         @(posedge sys_clk); #1;
      end
      m_cyc = 0; m_stb = 0;
   endtask

   task automatic burst(input bit we_, input logic [31:0] a0, input int n,
                        output int first_lat, output int gaps, output int nack);
      logic [31:0] a;
      int wait_c;
      a = a0; first_lat = 0; gaps = 0; nack = 0;
      m_cyc = 1; m_stb = 1; m_we = we_; m_bte = BTE_LINEAR; m_sel = 4'hF;
      for (int k = 0; k < n; k++) begin
         m_adr = a; m_dat = $urandom;
         m_cti = (k == n - 1) ? CTI_EOB : CTI_INCR;
         push(we_, a);
         wait_c = 0;
         if (k == 0) begin @(posedge sys_clk); #1; wait_c = 1; end
         while (!(s_ack || s_err) && wait_c < 20) begin
            @(posedge sys_clk); #1; wait_c++;
         end
         if (k == 0) first_lat = wait_c; else gaps += wait_c;
         if (!(s_ack || s_err)) begin
            checks++; errors++;
            $display("FAIL burst_timeout beat=%0d adr=0x%08h no ack/err", k, a);
            exp_q.delete(exp_q.size() - 1);
            break;
         end
         if (s_err) begin @(posedge sys_clk); #1; break; end
         nack++;
         if (we_) model_write(a, m_dat, 4'hF);
         @(posedge sys_clk); #1;
         a = a + 32'd4;
      end
      m_cyc = 0; m_stb = 0; m_cti = CTI_CLASSIC;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   int          lat, fl, gp, na;
   bit          ge;
   logic [31:0] rd, d0, expd;

   initial begin
      dsel = 0;
      m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat = '0;
      m_sel = '0; m_cti = CTI_CLASSIC; m_bte = BTE_LINEAR;
      sys_rst_n = 1'b1;
      #2 sys_rst_n = 1'b0;
      #3;
      chk("rst_ack0", 32'(bus0.ack), 0);
      chk("rst_err0", 32'(bus0.err), 0);
      chk("rst_dat0", bus0.dat_sm, 0);
      chk("rst_ack2", 32'(bus2.ack), 0);
      chk("rst_dat2", bus2.dat_sm, 0);
      chk("rty_tied", 32'(bus0.rty), 0);
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk) sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;

      // Fill words 0..63 with one long write burst.
      burst(1, 32'h0, 64, fl, gp, na);
      chk("fill_first_lat", fl, 1);
      chk("fill_gaps", gp, 0);
      chk("fill_beats", na, 64);

      classic(1, 32'h10, 32'hDEADBEEF, 4'hF, lat, ge, rd);
      chk("wr_latency", lat, 1);
      classic(0, 32'h10, 32'h0, 4'hF, lat, ge, rd);
      chk("rd_latency", lat, 1);
      chk("rd_deadbeef", rd, 32'hDEADBEEF);

      classic(1, 32'h10, 32'h000000AA, 4'b0001, lat, ge, rd);
      classic(0, 32'h10, 32'h0, 4'hF, lat, ge, rd);
      chk("byte_lane_merge", rd, 32'hDEADBEAA);

      burst(0, 32'h20, 4, fl, gp, na);
      chk("rdburst_first_lat", fl, 1);
      chk("rdburst_gaps", gp, 0);
      chk("rdburst_beats", na, 4);
      chk("rdburst_ack_low_after", 32'(s_ack), 0);

      classic(1, 32'h30, 32'h12345678, 4'h0, lat, ge, rd);
      classic(0, 32'h30, 32'h0, 4'hF, lat, ge, rd);

      classic(0, 32'h40, 32'h0, 4'hF, lat, ge, rd);
      expd = mdl[key(32'h40)];
      classic(1, 32'h0000_1000, 32'hFFFFFFFF, 4'hF, lat, ge, rd);
      chk("oor_err", 32'(ge), 1);
      chk("oor_latency", lat, 1);
      chk("oor_dat_unchanged", s_dat, expd);
      classic(0, 32'h0, 32'h0, 4'hF, lat, ge, rd);

      burst(1, 32'hFF8, 4, fl, gp, na);
      chk("cross_wr_beats", na, 2);
      burst(0, 32'hFF8, 4, fl, gp, na);
      chk("cross_rd_beats", na, 2);

      for (int i = 0; i < 150; i++) begin
         int op, w, n;
         op = $urandom_range(0, 9);
         w  = $urandom_range(0, 63);
         case (op)
            0, 1, 2, 3: classic(1, 32'(w * 4) | 32'($urandom_range(0, 3)), $urandom,
                                4'($urandom_range(0, 15)), lat, ge, rd);
            4, 5, 6:    classic(0, 32'(w * 4) | 32'($urandom_range(0, 3)), 32'h0,
                                4'hF, lat, ge, rd);
            7, 8: begin
               n = $urandom_range(1, 6);
               w = $urandom_range(0, 64 - n);
               burst(op == 8, 32'(w * 4), n, fl, gp, na);
               chk("rand_burst_gaps", gp, 0);
               chk("rand_burst_beats", na, n);
            end
            default: begin
               classic($urandom_range(0, 1) == 1, ($urandom | 32'h0000_1000) & ~32'h3,
                       $urandom, 4'hF, lat, ge, rd);
               chk("rand_oor_err", 32'(ge), 1);
            end
         endcase
      end

      // Reset pulsed while the second beat of a write burst is being acked.
      d0 = $urandom;
      m_cyc = 1; m_stb = 1; m_we = 1; m_bte = BTE_LINEAR; m_sel = 4'hF;
      m_adr = 32'(40 * 4); m_dat = d0; m_cti = CTI_INCR;
      push(1, m_adr);
      lat = 0;
      do begin @(posedge sys_clk); #1; lat++; end while (!s_ack && lat < 20);
      chk("rstburst_beat1_ack", 32'(s_ack), 1);
      if (s_ack) model_write(32'(40 * 4), d0, 4'hF);
      else exp_q.delete(exp_q.size() - 1);
      @(posedge sys_clk); #1;
      m_adr = 32'(41 * 4); m_dat = ~d0;
      chk("rstburst_beat2_ack", 32'(s_ack), 1);
      #1 sys_rst_n = 1'b0;
      #1;
      chk("rstburst_ack_cleared", 32'(s_ack), 0);
      chk("rstburst_err_cleared", 32'(s_err), 0);
      chk("rstburst_dat_cleared", s_dat, 0);
      @(posedge sys_clk); #1;
      m_adr = 32'(42 * 4);
      @(posedge sys_clk);
      @(negedge sys_clk) sys_rst_n = 1'b1;
      m_cyc = 0; m_stb = 0; m_cti = CTI_CLASSIC;
      @(posedge sys_clk); #1;
      burst(0, 32'(36 * 4), 8, fl, gp, na);
      chk("post_rst_beats", na, 8);

      // Two-wait-state instance.
      dsel = 1;
      @(posedge sys_clk); #1;
      classic(1, 32'h100, 32'hCAFEF00D, 4'hF, lat, ge, rd);
      chk("ws2_wr_latency", lat, 3);
      classic(0, 32'h100, 32'h0, 4'hF, lat, ge, rd);
      chk("ws2_rd_latency", lat, 3);
      chk("ws2_rd_data", rd, 32'hCAFEF00D);
      burst(1, 32'h200, 3, fl, gp, na);
      burst(0, 32'h200, 3, fl, gp, na);
      chk("ws2_burst_first_lat", fl, 3);
      chk("ws2_burst_gaps", gp, 0);
      chk("ws2_burst_beats", na, 3);
      classic(0, 32'h0000_2000, 32'h0, 4'hF, lat, ge, rd);
      chk("ws2_oor_err", 32'(ge), 1);
      chk("ws2_oor_latency", lat, 3);

      repeat (3) @(posedge sys_clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wshb_ram_slave.md
WSHB_RAM_SLAVE -- requirements
Module: wshb_ram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-address bits; on-chip depth = 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 0: extra idle cycles inserted before the first beat of each access.
REQ-003 Port sys_clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 Port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port cyc, input, 1 bit: Wishbone cycle.
REQ-006 Port stb, input, 1 bit: Wishbone strobe.
REQ-007 Port we, input, 1 bit: write enable.
REQ-008 Port adr, input, 32 bits: byte address; adr[1:0] ignored.
REQ-009 Port dat_ms, input, 32 bits: write data.
REQ-010 Port sel, input, 4 bits: byte lane enables.
REQ-011 Port cti, input, 3 bits: cycle type (000 classic, 010 incrementing, 111 end-of-burst).
REQ-012 Port bte, input, 2 bits: burst type.
REQ-013 Port dat_sm, output, 32 bits: read data, valid when ack=1.
REQ-014 Port ack, output, 1 bit: registered acknowledge.
REQ-015 Port err, output, 1 bit: registered error acknowledge.
REQ-016 Port rty, output, 1 bit: tied 0.

Function
REQ-017 New request SHALL be sampled when cyc & stb & !ack & !err and state is IDLE.
REQ-018 In-range test SHALL be adr[31:ADDR_WIDTH+2] == 0; word index = adr[ADDR_WIDTH+1:2].
REQ-019 FSM states SHALL be IDLE, WAIT, BURST; IDLE->WAIT on request when WAIT_STATES>0, IDLE->BURST on request when WAIT_STATES=0; WAIT->BURST after exactly WAIT_STATES counted cycles.
REQ-020 With WAIT_STATES=0, ack (or err) SHALL assert the cycle after the request is sampled; latency = 1+WAIT_STATES cycles.
REQ-021 Out-of-range request SHALL produce a one-cycle err instead of ack, no memory write, dat_sm unchanged; state returns to IDLE.
REQ-022 Classic cycle (cti 000 or 111, or bte != 00): ack SHALL be a single-cycle pulse, then IDLE; back-to-back classic accesses therefore ack at most every 2nd cycle.
REQ-023 Incrementing linear burst (cti=010, bte=00): in BURST, ack SHALL stay high every cycle while cyc & stb & cti=010 persist; read data SHALL come from an internal pointer incremented by one word per acked beat, wrapping modulo depth.
REQ-024 Burst end: beat acked with cti=111 SHALL be the last; ack low the following cycle, state IDLE.
REQ-025 If stb or cyc drops while in BURST or WAIT, ack/err SHALL be 0 the next cycle and state IDLE; no write for the unacked beat.
REQ-026 Write SHALL commit on the edge where ack & cyc & stb & we, at the master's current adr, byte lanes per sel only; sel=0000 acks without changing memory.
REQ-027 Beat crossing out of range mid-burst SHALL terminate with err on that beat.
REQ-028 ack and err SHALL never be high in the same cycle.

Reset
REQ-029 Assertion of sys_rst_n=0 SHALL immediately force state IDLE, ack=0, err=0, dat_sm=0, wait counter=0, burst pointer=0.
REQ-030 Memory contents SHALL NOT be cleared by reset; reset mid-burst aborts with no further writes.

Structure
REQ-031 Package wshb_pkg SHALL hold the cti/bte encodings (CTI_CLASSIC, CTI_INCR, CTI_EOB, BTE_LINEAR) and the FSM state enum.
REQ-032 Storage SHALL be a sub-module wshb_ram_bank: byte-enable write, 1-cycle registered read, inferable as block RAM.

Verification
REQ-033 Classic write 0xDEADBEEF to adr 0x10, sel=1111, then read 0x10 -> ack one cycle after each request, dat_sm=0xDEADBEEF.
REQ-034 Write 0x000000AA with sel=0001 over 0xDEADBEEF at 0x10 -> read returns 0xDEADBEAA.
REQ-035 Read burst of 4 from 0x20 (cti 010,010,010,111) with WAIT_STATES=0 -> 4 consecutive ack cycles, data of words 8..11, ack low afterwards.
REQ-036 WAIT_STATES=2, classic read -> ack exactly 3 cycles after request sampled.
REQ-037 Access adr 0x0000_1000 with ADDR_WIDTH=10 -> one-cycle err, ack=0, memory unchanged.
REQ-038 sys_rst_n pulsed low during burst beat 2 -> ack=0 immediately, remaining beats not written, earlier beats retained.
